seg7_scan_mux: RTL



---
 rtl/seg7_scan_mux.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed 4-digit common-anode seven-segment driver
// Frame-coherent snapshot of the stopwatch digits, leading-zero blanking, blinking MM.SS point.
module seg7_scan_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic       blank_lead,
  input  logic       dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} idx_t;

  idx_t          idx;
  idx_t          idx_next;
  logic [PW-1:0] pre;
  logic          tick;
  logic          frame_wrap;
  logic [3:0]    snap0;
  logic [3:0]    snap1;
  logic [3:0]    snap2;
  logic [3:0]    snap3;
  logic [FW-1:0] fc;
  logic          phase;
  logic [3:0]    sel;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

  assign tick       = (pre == PRE_MAX);
  assign frame_wrap = tick && (idx == D3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= D0;
    end else begin
      idx <= idx_next;
    end
  end

  always_comb begin
    idx_next = idx;
    an_next  = 4'b1111;
    sel      = snap0;
    case (idx)
      D0: begin
        if (tick) idx_next = D1;
        an_next = 4'b1110;
        sel     = snap0;
      end
      D1: begin
        if (tick) idx_next = D2;
        an_next = 4'b1101;
        sel     = snap1;
      end
      D2: begin
        if (tick) idx_next = D3;
        an_next = 4'b1011;
        sel     = snap2;
      end
      D3: begin
        if (tick) idx_next = D0;
        an_next = 4'b0111;
        sel     = snap3;
      end
    endcase
    seg_next = seg_decode(sel);
    if ((idx == D3) && blank_lead && (snap3 == 4'd0)) seg_next = SEG_OFF;
    dp_next = !((idx == D2) && dp_en && phase);
  end

  // Snapshot reloads only between frames so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap0 <= '0;
      snap1 <= '0;
      snap2 <= '0;
      snap3 <= '0;
      fc    <= '0;
      phase <= 1'b0;
    end else if (frame_wrap) begin
      snap0 <= num0;
      snap1 <= num1;
      snap2 <= num2;
      snap3 <= num3;
      if (fc == FC_MAX) begin
        fc    <= '0;
        phase <= ~phase;
      end else begin
        fc <= fc + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
